// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, issues one instruction-memory request at a
// time, buffers the returned instruction for decode and applies redirects.
//
// state   | meaning
// S_IDLE  | first cycle after reset, no request yet
// S_REQ   | imem_req driven until the memory accepts it
// S_WAIT  | one request outstanding, waiting for rvalid
// S_HOLD  | instruction buffered, waiting for decode to take it
// S_DRAIN | redirected while outstanding; discard the stale response
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        is_jal,
  input  logic [31:0] jal_target,
  input  logic        is_jalr,
  input  logic [31:0] jalr_target,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic [31:0] pc
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t      state, state_nxt;
  logic        redirect;
  logic [31:0] target;

  assign redirect = is_jal | is_jalr | (branch & branch_taken);

  always_comb begin
    target = branch_target;
    if (is_jal)       target = jal_target;
    else if (is_jalr) target = {jalr_target[31:1], 1'b0};
  end

  // A redirect in REQ suppresses the request so the stale address never issues.
  assign imem_req  = (state == S_REQ) && !redirect;
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_REQ;
      S_REQ:   if (!redirect && imem_ready) state_nxt = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid && !redirect)      state_nxt = S_HOLD;
        else if (imem_rvalid && redirect)  state_nxt = S_REQ;
        else if (redirect)                 state_nxt = S_DRAIN;
      end
      S_HOLD:  if (redirect || if_ready) state_nxt = S_REQ;
      S_DRAIN: if (imem_rvalid) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_instr <= 32'h0;
    end else begin
      case (state)
        S_IDLE, S_REQ, S_DRAIN: begin
          if (redirect) pc <= target;
        end
        S_WAIT: begin
          if (redirect) begin
            pc <= target;
          end else if (imem_rvalid) begin
            if_instr <= imem_rdata;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= pc + 32'd4;
          end
        end
        S_HOLD: begin
          // The buffered instruction is younger than the redirecting one: flush it.
          if (redirect) begin
            if_valid <= 1'b0;
            pc       <= target;
          end else if (if_ready) begin
            if_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
